// File: rtl/two_bit_serial_adder.sv
// two_bit_serial_adder: sequential WIDTH-bit adder consuming two operand bits per clock.
//   Ports: i_clk (rising edge), i_rst_n (async active-low reset), i_start (launch),
//          i_a/i_b (operands, captured on the accepting edge), i_cin (carry-in, only with
//          SERIAL_ADD_CIN_EN), o_busy (RUN), o_done (one-cycle result-valid pulse),
//          o_sum (a+b(+cin) mod 2^WIDTH), o_cout (carry out of bit WIDTH-1).
//   Macro SERIAL_ADD_CIN_EN: adds i_cin and seeds the carry register from it.
//   WIDTH must be even and >= 2.
module two_bit_add_slice (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    input  logic       i_c,
    output logic [1:0] o_s,
    output logic       o_c
);
    assign {o_c, o_s} = 3'(i_a) + 3'(i_b) + 3'(i_c);
endmodule

module two_bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
`ifdef SERIAL_ADD_CIN_EN
    input  logic             i_cin,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    localparam int SLICES = WIDTH / 2;
    localparam int CW     = $clog2(SLICES + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_part;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_cin;
    logic [1:0]       w_s;
    logic             w_c;
    logic [WIDTH+1:0] w_ext;
    logic [WIDTH-1:0] w_part_nxt;
    logic             w_accept;
    logic             w_last;

`ifdef SERIAL_ADD_CIN_EN
    assign w_cin = i_cin;
`else
    assign w_cin = 1'b0;
`endif

    two_bit_add_slice u_slice (
        .i_a(r_opa[1:0]),
        .i_b(r_opb[1:0]),
        .i_c(r_carry),
        .o_s(w_s),
        .o_c(w_c)
    );

    // New slice enters at the top; concatenating then dropping two LSBs also covers WIDTH=2.
    assign w_ext      = {w_s, r_part};
    assign w_part_nxt = w_ext[WIDTH+1:2];
    assign w_accept   = i_start && (r_state == IDLE || r_state == DONE);
    assign w_last     = r_cnt == CW'(SLICES - 1);

    assign o_busy = r_state == RUN;
    assign o_done = r_state == DONE;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_part  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_state <= RUN;
            r_opa   <= i_a;
            r_opb   <= i_b;
            r_part  <= '0;
            r_carry <= w_cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_opa   <= r_opa >> 2;
            r_opb   <= r_opb >> 2;
            r_part  <= w_part_nxt;
            r_carry <= w_c;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_state <= DONE;
                r_sum   <= w_part_nxt;
                r_cout  <= w_c;
            end
        end else begin
            r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_two_bit_serial_adder.sv
// tb_two_bit_serial_adder: randomized self-checking bench against an arithmetic reference.
module tb_two_bit_serial_adder;
`ifdef SERIAL_ADD_CIN_EN
    localparam bit CIN_EN = 1'b1;
`else
    localparam bit CIN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cin = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start2 = 1'b0;
    logic       cin2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;

    int checks = 0;
    int failures = 0;
    logic [8:0] prev = '0;

    always #5 clk = ~clk;

    two_bit_serial_adder #(.WIDTH(8)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start(start),
        .i_a(a),
        .i_b(b),
`ifdef SERIAL_ADD_CIN_EN
        .i_cin(cin),
`endif
        .o_busy(busy),
        .o_done(done),
        .o_sum(sum),
        .o_cout(cout)
    );

    two_bit_serial_adder #(.WIDTH(2)) dut2 (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start(start2),
        .i_a(a2),
        .i_b(b2),
`ifdef SERIAL_ADD_CIN_EN
        .i_cin(cin2),
`endif
        .o_busy(busy2),
        .o_done(done2),
        .o_sum(sum2),
        .o_cout(cout2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc, input bit disturb);
        logic [8:0] e;
        e = 9'(ta) + 9'(tb_v) + 9'(tc & CIN_EN);
        a = ta;
        b = tb_v;
        cin = tc;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_done", done, 0);
        for (int k = 1; k <= 4; k++) begin
            if (disturb) begin
                a = 8'($urandom);
                b = 8'($urandom);
                cin = 1'($urandom);
                start = (k == 1);
            end
            tick;
            if (k < 4) begin
                chk("run_busy", busy, 1);
                chk("run_done", done, 0);
                chk("run_hold", {cout, sum}, prev);
            end
        end
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        chk("sum", sum, e[7:0]);
        chk("cout", cout, e[8]);
        prev = e;
        tick;
        chk("done_pulse", done, 0);
        chk("result_hold", {cout, sum}, prev);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", {cout, sum}, 0);
        chk("rst2_outputs", {busy2, done2, cout2, sum2}, 0);
        rst_n = 1'b1;
        tick;

        run_op(8'h0F, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        run_op(8'h33, 8'h11, 1'b0, 1'b1);
`ifdef SERIAL_ADD_CIN_EN
        run_op(8'hFF, 8'h00, 1'b1, 1'b0);
`endif
        for (int i = 0; i < 20; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

        a = 8'h01;
        b = 8'h01;
        cin = 1'b0;
        start = 1'b1;
        tick;
        for (int c = 1; c <= 15; c++) begin
            tick;
            chk("held_done", done, (c % 5) == 4);
            chk("held_busy", busy, (c % 5) != 4);
            if ((c % 5) == 4)
                chk("held_sum", {cout, sum}, 9'h002);
        end
        start = 1'b0;
        repeat (4) tick;
        chk("held_last", done, 1);
        prev = 9'h002;
        tick;

        a = 8'h5A;
        b = 8'h11;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", {cout, sum}, 0);
        prev = '0;
        repeat (3) begin
            tick;
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
        end
        rst_n = 1'b1;
        tick;
        run_op(8'h20, 8'h22, 1'b0, 1'b0);

        for (int i = 0; i < 32; i++) begin
            logic [2:0] e2;
            a2 = i[1:0];
            b2 = i[3:2];
            cin2 = i[4];
            e2 = 3'(a2) + 3'(b2) + 3'(cin2 & CIN_EN);
            start2 = 1'b1;
            tick;
            start2 = 1'b0;
            chk("w2_busy", busy2, 1);
            tick;
            chk("w2_done", done2, 1);
            chk("w2_idle", busy2, 0);
            chk("w2_result", {cout2, sum2}, e2);
            tick;
            chk("w2_pulse", done2, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/two_bit_serial_adder.md
# two_bit_serial_adder

Sequential N-bit adder that consumes operands two bits per clock, using a 2-bit add slice with a registered carry chained between cycles. It sits directly downstream of the lab's 2-bit combinational adder stage and turns its per-slice sum and carry outputs into a full-width result. A single start pulse launches an operation; a one-cycle done pulse marks a valid result.

## Interface
Parameters:
- WIDTH, 8: operand/result width in bits; must be even and ≥2. Odd values are illegal and give undefined behaviour.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, reset asynchronous and active-low
- start  input  1  launch request; sampled on rising edge of clk
- a  input  WIDTH  operand A; sampled only on the edge that accepts start
- b  input  WIDTH  operand B; sampled only on the edge that accepts start
- cin  input  1  carry-in; present only with SERIAL_ADD_CIN_EN
- busy  output  1  high while slices are being processed (RUN)
- done  output  1  one-cycle pulse; sum/cout valid
- sum  output  WIDTH  result, a+b(+cin) mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1

## Operation
- Internal state: FSM {IDLE, RUN, DONE}; operand shift registers opa/opb (WIDTH); partial-sum shift register (WIDTH); carry register (1); slice counter, width ceil(log2(WIDTH/2+1)).
- IDLE: busy=0, done=0. start=1 → load opa=a, opb=b, carry=0 (or cin), counter=0, partial=0; go RUN.
- RUN: each edge computes {c,s[1:0]} = opa[1:0] + opb[1:0] + carry; carry←c; partial shifts right by 2 with s entering partial[WIDTH-1:WIDTH-2]; opa/opb shift right by 2; counter+1. When counter reaches WIDTH/2-1 on this edge (last slice), go DONE and load sum←final partial, cout←final carry.
- DONE: done=1, busy=0 for exactly one cycle. Next edge: start=1 → accepted as from IDLE (go RUN); else go IDLE.
- start while in RUN is ignored; a/b/cin changes during RUN have no effect.
- sum and cout change only on entry to DONE; they hold the previous result at all other times, including during RUN.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true bit-WIDTH carry.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0, all internal registers 0. Reset mid-RUN aborts; no done is produced and sum/cout read 0.
- Accepting edge E0 (start=1 in IDLE/DONE) → busy=1 after E0.
- Slices are processed on edges E1..E(WIDTH/2); done=1 and new sum/cout are visible after E(WIDTH/2), busy=0 from the same point.
- Latency: WIDTH/2 cycles from accepting edge to done; throughput is one result per WIDTH/2+1 cycles with start held or re-pulsed in DONE.
- WIDTH=2: a single RUN cycle; done follows E1.

## Configuration
- SERIAL_ADD_CIN_EN defined: port cin exists and is captured into the carry register on the accepting edge; result = a+b+cin.
- Undefined: no cin port; the carry register initialises to 0; result = a+b.

## Test plan
- WIDTH=8, reset, start with a=8'h0F, b=8'h01 → busy high for 4 cycles, done after E4, sum=8'h10, cout=0, single-cycle done.
- WIDTH=8, a=8'hFF, b=8'h01 → sum=8'h00, cout=1; then a=8'hFF, b=8'hFF → sum=8'hFE, cout=1.
- start re-pulsed during RUN and a/b changed mid-op (a=8'h33, b=8'h11 captured) → sum=8'h44 at done after E4; the second start is ignored.
- Start held high continuously with a=8'h01, b=8'h01 → done every 5 cycles, sum=8'h02 each time, no IDLE cycle between operations.
- rst_n low at E2 of an operation → busy, done, sum and cout immediately 0; no done pulse; next start completes normally.
- With SERIAL_ADD_CIN_EN, a=8'hFF, b=8'h00, cin=1 → sum=8'h00, cout=1; WIDTH=2, a=2'b11, b=2'b01 → done after E1, sum=2'b00, cout=1.
